tensor_core_scheduler: RTL and testbench

Arbitrates two requesters (instruction decoder lane 0, DMA/preload lane 1) for the single small tensor core. Sequences one 9-element 3x3 matrix operation per grant: pulses the core start, runs 5 result beats, and writes results to the register file two elements per beat. Signals completion per requester. Sits between the request sources, the tensor core and the register file write ports.

---
 rtl/tensor_core_scheduler_if.sv | 41 ++++
 rtl/tensor_core_scheduler.sv | 84 ++++++++
 tb/tb_tensor_core_scheduler.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/tensor_core_scheduler_if.sv
// tensor_core_scheduler_if: request, tensor-core and register-file signals of the scheduler
// Perf counter signals exist only when TENSOR_SCHED_PERF_COUNTERS_EN is defined.
interface tensor_core_scheduler_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
);
    logic [1:0]                       req_valid;
    logic [1:0]                       req_ready;
    logic [1:0][2:0]                  req_op;
    logic [1:0][ADDR_WIDTH-1:0]       req_dest;
    logic                             core_start;
    logic [2:0]                       core_op_select;
    logic [1:0][DATA_WIDTH-1:0]       core_result;
    logic [1:0]                       rf_write_enable;
    logic [1:0][ADDR_WIDTH-1:0]       rf_write_addr;
    logic [1:0][DATA_WIDTH-1:0]       rf_write_data;
    logic                             busy;
    logic                             done_pulse;
    logic                             done_id;
    logic                             done_error;
`ifdef TENSOR_SCHED_PERF_COUNTERS_EN
    logic [15:0]                      perf_ops_completed;
    logic [15:0]                      perf_wait_cycles;
`endif
    modport master (
        output req_valid, req_op, req_dest, core_result,
        input  req_ready, core_start, core_op_select, rf_write_enable, rf_write_addr,
               rf_write_data, busy, done_pulse, done_id, done_error
`ifdef TENSOR_SCHED_PERF_COUNTERS_EN
        , input perf_ops_completed, perf_wait_cycles
`endif
    );
    modport slave (
        input  req_valid, req_op, req_dest, core_result,
        output req_ready, core_start, core_op_select, rf_write_enable, rf_write_addr,
               rf_write_data, busy, done_pulse, done_id, done_error
`ifdef TENSOR_SCHED_PERF_COUNTERS_EN
        , output perf_ops_completed, perf_wait_cycles
`endif
    );
endinterface

// File: rtl/tensor_core_scheduler.sv
// tensor_core_scheduler: round-robin arbiter and 3x3 op sequencer between two requesters and the tensor core
// Optional perf counters: define TENSOR_SCHED_PERF_COUNTERS_EN.
module tensor_core_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_ELEMS  = 9
) (
    input  logic clock_in,
    input  logic reset_n_in,
    tensor_core_scheduler_if.slave bus
);
    localparam int BEATS = (NUM_ELEMS + 1) / 2;
    localparam int BW = $clog2(BEATS + 1);
    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [BW-1:0] beat;
    logic [2:0] op_q;
    logic [ADDR_WIDTH-1:0] dest_q, base;
    logic [1:0] en;
    logic last_grant, grant, accept, id_q, err_q, last_beat;
    always_comb begin
        grant = &bus.req_valid ? ~last_grant : bus.req_valid[1];
        accept = state == IDLE && |bus.req_valid;
        last_beat = beat == BW'(BEATS - 1);
        state_nx = state;
        case (state)
            IDLE:  state_nx = accept ? (bus.req_op[grant] > 3'd2 ? DONE : START) : IDLE;
            START: state_nx = RUN;
            RUN:   state_nx = last_beat ? DONE : RUN;
            DONE:  state_nx = IDLE;
        endcase
    end
    // An odd element count leaves lane 1 idle on the final beat
    always_comb begin
        base = dest_q + ADDR_WIDTH'({beat, 1'b0});
        en = state != RUN ? 2'b00 : (last_beat && NUM_ELEMS % 2 == 1) ? 2'b01 : 2'b11;
        bus.req_ready = accept ? {grant, ~grant} : 2'b00;
        bus.core_start = state == START;
        bus.core_op_select = state == IDLE ? 3'd0 : op_q;
        bus.rf_write_enable = en;
        for (int i = 0; i < 2; i++) begin
            bus.rf_write_addr[i] = en[i] ? base + ADDR_WIDTH'(i) : '0;
            bus.rf_write_data[i] = en[i] ? bus.core_result[i] : DATA_WIDTH'(0);
        end
        bus.busy = state != IDLE;
        bus.done_pulse = state == DONE;
        bus.done_id = state == DONE && id_q;
        bus.done_error = state == DONE && err_q;
    end
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state <= IDLE;
            beat <= '0;
            last_grant <= 1'b1;
            op_q <= '0;
            dest_q <= '0;
            id_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            beat <= state == RUN ? beat + 1'b1 : '0;
            if (accept) begin
                last_grant <= grant;
                id_q <= grant;
                op_q <= bus.req_op[grant];
                dest_q <= bus.req_dest[grant];
                err_q <= bus.req_op[grant] > 3'd2;
            end
        end
    end
`ifdef TENSOR_SCHED_PERF_COUNTERS_EN
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            bus.perf_ops_completed <= '0;
            bus.perf_wait_cycles <= '0;
        end else begin
            if (state == DONE && !err_q && ~&bus.perf_ops_completed)
                bus.perf_ops_completed <= bus.perf_ops_completed + 1'b1;
            if (state != IDLE && |bus.req_valid && ~&bus.perf_wait_cycles)
                bus.perf_wait_cycles <= bus.perf_wait_cycles + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_tensor_core_scheduler.sv
// tb_tensor_core_scheduler: directed stimulus with a timeline model of each accepted operation
module tb_tensor_core_scheduler;
    logic clock_in = 1'b0;
    logic reset_n_in = 1'b0;
    int cyc = 0, n_checks = 0, n_errors = 0;
    tensor_core_scheduler_if bus ();
    tensor_core_scheduler dut (.clock_in(clock_in), .reset_n_in(reset_n_in), .bus(bus));
    always #5 clock_in = ~clock_in;
    always @(posedge clock_in) cyc <= cyc + 1;
    always @(posedge clock_in) begin
        #2;
        bus.core_result[0] = 8'(2 * cyc);
        bus.core_result[1] = 8'(2 * cyc + 1);
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask
    // Model: each accepted op is a fixed timeline relative to its accept cycle
    int acc_c = -1000, rel, k;
    logic m_last = 1'b1, m_id = 1'b0, m_err = 1'b0, busy_e, done_e, g;
    logic [2:0] m_op = '0;
    logic [4:0] m_dest = '0;
    logic [1:0] en_e, ready_e;
    always @(negedge clock_in) begin
        if (!reset_n_in) begin
            acc_c = -1000;
            m_last = 1'b1;
            m_err = 1'b0;
            check("reset_outputs", {bus.req_ready, bus.core_start, bus.core_op_select, bus.rf_write_enable,
                                    bus.busy, bus.done_pulse, bus.done_id, bus.done_error}, 0);
        end else begin
            rel = cyc - acc_c;
            busy_e = rel >= 1 && rel <= (m_err ? 1 : 7);
            k = rel - 2;
            en_e = (m_err || k < 0 || k > 4) ? 2'b00 : (k == 4 ? 2'b01 : 2'b11);
            done_e = busy_e && rel == (m_err ? 1 : 7);
            ready_e = 2'b00;
            g = 1'b0;
            if (!busy_e && bus.req_valid != 2'b00) begin
                g = bus.req_valid == 2'b11 ? !m_last : bus.req_valid[1];
                ready_e = g ? 2'b10 : 2'b01;
            end
            check("req_ready", bus.req_ready, ready_e);
            check("core_start", bus.core_start, busy_e && !m_err && rel == 1);
            check("core_op_select", bus.core_op_select, busy_e ? m_op : 3'd0);
            check("busy", bus.busy, busy_e);
            check("rf_write_enable", bus.rf_write_enable, en_e);
            for (int i = 0; i < 2; i++)
                if (en_e[i]) begin
                    check("rf_write_addr", bus.rf_write_addr[i], 5'(m_dest + 5'(2 * k + i)));
                    check("rf_write_data", bus.rf_write_data[i], bus.core_result[i]);
                end
            check("done_pulse", bus.done_pulse, done_e);
            check("done_id", bus.done_id, done_e && m_id);
            check("done_error", bus.done_error, done_e && m_err);
            if (ready_e != 2'b00) begin
                acc_c = cyc;
                m_last = g;
                m_id = g;
                m_op = bus.req_op[g];
                m_dest = bus.req_dest[g];
                m_err = bus.req_op[g] > 3'd2;
            end
        end
    end
    task automatic tick;
        @(posedge clock_in);
        #1;
    endtask
    task automatic go_neg(input int c);
        do @(negedge clock_in); while (cyc < c);
    endtask
    task automatic wait_accept(input int lane, output int t);
        t = -1;
        for (int i = 0; i < 40 && t < 0; i++) begin
            @(negedge clock_in);
            if (bus.req_ready[lane] && bus.req_valid[lane]) t = cyc;
        end
        check("accept_seen", t >= 0, 1);
    endtask
    task automatic wait_idle;
        for (int i = 0; i < 20 && bus.busy; i++) @(negedge clock_in);
        check("idle_reached", bus.busy, 0);
    endtask
    int t, n;
    logic gl[4];
    int gc[4];
    initial begin
        bus.req_valid = '0;
        bus.req_op = '0;
        bus.req_dest = '0;
        bus.core_result = '0;
        repeat (3) @(negedge clock_in);
        check("reset_busy", bus.busy, 0);
        tick;
        reset_n_in = 1'b1;
        // lane 0 matmul to dest 4
        bus.req_op[0] = 3'd0;
        bus.req_dest[0] = 5'd4;
        bus.req_valid = 2'b01;
        wait_accept(0, t);
        check("t1_ready", bus.req_ready, 2'b01);
        tick;
        bus.req_valid = 2'b00;
        go_neg(t + 1);
        check("t1_start", bus.core_start, 1);
        go_neg(t + 2);
        check("t1_addr0_b0", bus.rf_write_addr[0], 4);
        check("t1_addr1_b0", bus.rf_write_addr[1], 5);
        check("t1_en_b0", bus.rf_write_enable, 2'b11);
        check("t1_data_b0", bus.rf_write_data[0], 8'(2 * cyc));
        go_neg(t + 6);
        check("t1_addr0_b4", bus.rf_write_addr[0], 12);
        check("t1_en_b4", bus.rf_write_enable, 2'b01);
        go_neg(t + 7);
        check("t1_done", bus.done_pulse, 1);
        check("t1_done_id", bus.done_id, 0);
        go_neg(t + 8);
        check("t1_idle", bus.busy, 0);
        // both lanes valid after a fresh reset: strict alternation from lane 0
        tick;
        reset_n_in = 1'b0;
        tick;
        tick;
        reset_n_in = 1'b1;
        bus.req_op = {3'd1, 3'd1};
        bus.req_dest = {5'd16, 5'd8};
        bus.req_valid = 2'b11;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock_in);
            if (bus.req_ready != 2'b00 && n < 4) begin
                gl[n] = bus.req_ready[1];
                gc[n] = cyc;
                n++;
            end
        end
        check("rr_count", n, 4);
        if (n == 4) begin
            check("rr_g0", gl[0], 0);
            check("rr_g1", gl[1], 1);
            check("rr_g2", gl[2], 0);
            check("rr_g3", gl[3], 1);
            check("rr_spacing", gc[1] - gc[0], 8);
        end
        tick;
        bus.req_valid = 2'b00;
        wait_idle;
        // address wrap from dest 30
        bus.req_op[0] = 3'd2;
        bus.req_dest[0] = 5'd30;
        bus.req_valid = 2'b01;
        wait_accept(0, t);
        tick;
        bus.req_valid = 2'b00;
        go_neg(t + 1);
        check("wrap_opsel", bus.core_op_select, 2);
        go_neg(t + 3);
        check("wrap_addr0_b1", bus.rf_write_addr[0], 0);
        check("wrap_addr1_b1", bus.rf_write_addr[1], 1);
        go_neg(t + 6);
        check("wrap_addr0_b4", bus.rf_write_addr[0], 6);
        go_neg(t + 7);
        check("wrap_no_error", bus.done_error, 0);
        tick;
        wait_idle;
        // illegal op on lane 1
        bus.req_op[1] = 3'd5;
        bus.req_dest[1] = 5'd3;
        bus.req_valid = 2'b10;
        wait_accept(1, t);
        tick;
        bus.req_valid = 2'b00;
        go_neg(t + 1);
        check("ill_done", bus.done_pulse, 1);
        check("ill_error", bus.done_error, 1);
        check("ill_id", bus.done_id, 1);
        check("ill_no_start", bus.core_start, 0);
        check("ill_no_write", bus.rf_write_enable, 0);
        go_neg(t + 2);
        check("ill_idle", bus.busy, 0);
        // reset during beat 2 aborts; lane 0 wins first afterwards
        bus.req_op[0] = 3'd0;
        bus.req_dest[0] = 5'd0;
        bus.req_valid = 2'b01;
        wait_accept(0, t);
        tick;
        bus.req_valid = 2'b00;
        go_neg(t + 4);
        check("abort_beat2_en", bus.rf_write_enable, 2'b11);
        #2;
        reset_n_in = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_en", bus.rf_write_enable, 0);
        check("abort_addr", bus.rf_write_addr[0], 0);
        check("abort_done", bus.done_pulse, 0);
        tick;
        tick;
        reset_n_in = 1'b1;
        bus.req_op = {3'd0, 3'd0};
        bus.req_valid = 2'b11;
        @(negedge clock_in);
        check("post_reset_grant", bus.req_ready, 2'b01);
        tick;
        bus.req_valid = 2'b00;
        wait_idle;
        repeat (3) @(negedge clock_in);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end
endmodule
